// File: rtl/song_mem_pkg.sv
// Shared encodings and default sizing for the multi-slot song memory bank.
// Mode and FSM state enums plus a helper that maps a mode onto its resting state.
package song_mem_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 256;
  localparam int DEF_NUM_SLOTS  = 4;

  typedef enum logic [1:0] {
    MODE_AUTOPLAY = 2'b00,
    MODE_LEARNING = 2'b01,
    MODE_RECORD   = 2'b10,
    MODE_IDLE     = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_REC   = 2'b01,
    S_PLAY  = 2'b10,
    S_FETCH = 2'b11
  } state_e;

  // Resting state the FSM settles in for a given mode (S_FETCH is never a resting state).
  function automatic state_e mode_state(input mode_e m);
    case (m)
      MODE_RECORD: return S_REC;
      MODE_IDLE:   return S_IDLE;
      default:     return S_PLAY;
    endcase
  endfunction

endpackage

// File: rtl/song_ram.sv
// Simple dual-port synchronous RAM holding every slot back to back; address is {slot, index}.
// One write port and one registered read port, both on the rising edge of clk.
module song_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = 10
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_W];
  logic [DATA_WIDTH-1:0] r_rdata;

  // NOTE: the storage array has no reset so it maps onto block RAM; slot lengths
  // in the top decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/song_memory_bank.sv
// Multi-slot song store: records note streams per slot and replays them via a rd_req/rd_valid handshake.
// Optional macro SONG_LOOP_EN: an advance at end of a non-empty song restarts at note 0.
module song_memory_bank
  import song_mem_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int DEPTH      = DEF_DEPTH,
  parameter  int NUM_SLOTS  = DEF_NUM_SLOTS,
  localparam int DEPTH_W    = $clog2(DEPTH),
  localparam int SLOT_W     = $clog2(NUM_SLOTS),
  localparam int LEN_W      = DEPTH_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic [SLOT_W-1:0]     slot_sel,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  clear,
  input  logic                  rd_req,
  input  logic                  key_ok,
  input  logic                  rd_rst,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic                  full,
  output logic [LEN_W-1:0]      song_len,
  output logic [LEN_W-1:0]      play_pos
);

  state_e                r_state;
  logic [LEN_W-1:0]      r_len [NUM_SLOTS];
  logic [LEN_W-1:0]      r_play_pos;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_done;
  mode_e                 r_mode_q;
  logic [SLOT_W-1:0]     r_slot_q;

  mode_e                 w_mode;
  logic [LEN_W-1:0]      w_len;
  logic                  w_full;
  logic                  w_rewind;
  logic                  w_wr_ready;
  logic                  w_write;
  logic                  w_advance;
  logic                  w_issue;
  logic                  w_end;
  logic [DEPTH_W-1:0]    w_fetch_idx;
  logic [DATA_WIDTH-1:0] w_ram_q;

  assign w_mode     = mode_e'(mode);
  assign w_len      = r_len[slot_sel];
  assign w_full     = (w_len == LEN_W'(DEPTH));
  assign w_rewind   = rd_rst || (w_mode != r_mode_q) || (slot_sel != r_slot_q);
  assign w_wr_ready = (r_state == S_REC) && !w_full && !clear;
  assign w_write    = w_wr_ready && wr_valid;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_advance   = 1'b0;
    w_issue     = 1'b0;
    w_end       = 1'b0;
    w_fetch_idx = r_play_pos[DEPTH_W-1:0];
    case (w_mode)
      MODE_AUTOPLAY: w_advance = rd_req;
      MODE_LEARNING: w_advance = rd_req && key_ok;
      default:       w_advance = 1'b0;
    endcase
    // A rewind in the same cycle swallows the advance entirely.
    if ((r_state == S_PLAY) && w_advance && !w_rewind) begin
      if (r_play_pos < w_len) begin
        w_issue = 1'b1;
      end else begin
        w_end = 1'b1;
`ifdef SONG_LOOP_EN
        if (w_len != '0) begin
          w_issue     = 1'b1;
          w_fetch_idx = '0;
        end
`endif
      end
    end
  end

  song_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (SLOT_W + DEPTH_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_write),
    .i_waddr ({slot_sel, w_len[DEPTH_W-1:0]}),
    .i_wdata (wr_data),
    .i_re    (w_issue),
    .i_raddr ({slot_sel, w_fetch_idx}),
    .o_rdata (w_ram_q)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every read
  // below sees the value from before this clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      for (int i = 0; i < NUM_SLOTS; i++) r_len[i] <= '0;
      r_play_pos <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_mode_q   <= MODE_IDLE;
      r_slot_q   <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      r_done     <= w_end;
      r_mode_q   <= w_mode;
      r_slot_q   <= slot_sel;

      if (r_state == S_REC) begin
        if (clear)        r_len[slot_sel] <= '0;
        else if (w_write) r_len[slot_sel] <= w_len + 1'b1;
      end

      if (w_rewind)     r_play_pos <= '0;
      else if (w_issue) r_play_pos <= {1'b0, w_fetch_idx} + 1'b1;

      case (r_state)
        S_PLAY: begin
          if (w_issue) r_state <= S_FETCH;
          else         r_state <= mode_state(w_mode);
        end
        S_FETCH: begin
          // A mode change abandons the outstanding read; rd_data keeps its old note.
          if (w_mode != r_mode_q) begin
            r_state <= mode_state(w_mode);
          end else begin
            r_rd_data  <= w_ram_q;
            r_rd_valid <= 1'b1;
            r_state    <= S_PLAY;
          end
        end
        default: r_state <= mode_state(w_mode);
      endcase
    end
  end

  assign wr_ready = w_wr_ready;
  assign full     = w_full;
  assign song_len = w_len;
  assign play_pos = r_play_pos;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign done     = r_done;

endmodule

// File: tb/tb_song_memory_bank.sv
// Scoreboard bench for song_memory_bank: stimulus pushes expected read events, a negedge monitor pops and checks them.
// Expectations for end-of-song behaviour follow SONG_LOOP_EN when it is defined.
module tb_song_memory_bank;
  import song_mem_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 256;
  localparam int NS    = 4;
  localparam int SW    = 2;
  localparam int LW    = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode;
  logic [SW-1:0] slot_sel;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          clear;
  logic          rd_req;
  logic          key_ok;
  logic          rd_rst;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          done;
  logic          full;
  logic [LW-1:0] song_len;
  logic [LW-1:0] play_pos;

  song_memory_bank #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_SLOTS(NS)) dut (
    .clk(clk), .rst(rst), .mode(mode), .slot_sel(slot_sel),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .clear(clear),
    .rd_req(rd_req), .key_ok(key_ok), .rd_rst(rd_rst),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .full(full),
    .song_len(song_len), .play_pos(play_pos)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          v;
    logic          d;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t q_exp[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one rd_req pulse and push what should come back; requests are spaced 3 clocks.
  task automatic send_req(input logic exp_done, input logic exp_valid, input logic [DW-1:0] data);
    if (exp_done)  q_exp.push_back('{v: 1'b0, d: 1'b1, data: '0,   cyc: cyc + 1});
    if (exp_valid) q_exp.push_back('{v: 1'b1, d: 1'b0, data: data, cyc: cyc + 2});
    rd_req = 1'b1;
    tick(1);
    rd_req = 1'b0;
    tick(2);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (rd_valid === 1'b1 || done === 1'b1)) begin
      if (q_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got rd_valid=%0b done=%0b rd_data=0x%0h expected no event (cycle %0d)",
                 rd_valid, done, rd_data, cyc);
      end else begin
        e = q_exp.pop_front();
        check("evt_kind", {30'd0, rd_valid, done}, {30'd0, e.v, e.d});
        check("evt_cycle", cyc, e.cyc);
        if (e.v) check("rd_data", {24'd0, rd_data}, {24'd0, e.data});
      end
    end
  end

  logic [DW-1:0] notes [3];
  logic [DW-1:0] last_note;

  initial begin
    notes = '{8'h11, 8'h22, 8'h33};
    mode = MODE_IDLE; slot_sel = '0; wr_valid = 1'b0; wr_data = '0;
    clear = 1'b0; rd_req = 1'b0; key_ok = 1'b0; rd_rst = 1'b0;
    tick(3);
    rst = 1'b0;
    check("rst_song_len", song_len, 0);
    check("rst_play_pos", play_pos, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_done", done, 0);
    check("rst_wr_ready", wr_ready, 0);

    // Record three notes into slot 0.
    mode = MODE_RECORD;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = notes[i];
      check("rec_wr_ready", wr_ready, 1);
      tick(1);
    end
    wr_valid = 1'b0;
    check("rec_song_len", song_len, 3);
    check("rec_not_full", full, 0);

    // Autoplay the whole song, then one request past the end.
    mode = MODE_AUTOPLAY;
    tick(1);
    send_req(1'b0, 1'b1, 8'h11);
    send_req(1'b0, 1'b1, 8'h22);
    send_req(1'b0, 1'b1, 8'h33);
`ifdef SONG_LOOP_EN
    send_req(1'b1, 1'b1, 8'h11);
    check("end_play_pos", play_pos, 1);
    check("end_rd_data", rd_data, 8'h11);
`else
    send_req(1'b1, 1'b0, 8'h00);
    check("end_play_pos", play_pos, 3);
    check("end_rd_data", rd_data, 8'h33);
`endif

    // Learning: a wrong key does not advance, a correct key does.
    mode   = MODE_LEARNING;
    key_ok = 1'b0;
    tick(1);
    check("learn_rewind", play_pos, 0);
    send_req(1'b0, 1'b0, 8'h00);
    check("learn_miss_pos", play_pos, 0);
    key_ok = 1'b1;
    send_req(1'b0, 1'b1, 8'h11);
    check("learn_hit_pos", play_pos, 1);
    key_ok = 1'b0;

    // Fill slot 1, overflow, clear, re-record.
    mode     = MODE_RECORD;
    slot_sel = 2'd1;
    tick(1);
    for (int i = 0; i < DEPTH; i++) begin
      wr_valid = 1'b1;
      wr_data  = DW'(i) ^ 8'h80;
      tick(1);
    end
    check("fill_full", full, 1);
    check("fill_wr_ready", wr_ready, 0);
    check("fill_song_len", song_len, DEPTH);
    wr_data = 8'hAA;
    tick(1);
    check("overflow_dropped", song_len, DEPTH);
    clear = 1'b1;
    check("clear_blocks_write", wr_ready, 0);
    tick(1);
    clear    = 1'b0;
    wr_valid = 1'b0;
    check("clear_song_len", song_len, 0);
    check("clear_not_full", full, 0);
    wr_valid = 1'b1;
    wr_data  = 8'h5A;
    tick(1);
    wr_data = 8'hA5;
    tick(1);
    wr_valid = 1'b0;
    check("slot1_len", song_len, 2);
    slot_sel = 2'd0;
    check("slot0_len_kept", song_len, 3);

    // Rewind by slot change and by rd_rst; the concurrent rd_req must not fetch.
    mode = MODE_AUTOPLAY;
    tick(1);
    send_req(1'b0, 1'b1, 8'h11);
    send_req(1'b0, 1'b1, 8'h22);
    check("mid_play_pos", play_pos, 2);
    slot_sel = 2'd1;
    tick(1);
    check("slot_rewind", play_pos, 0);
    slot_sel = 2'd0;
    tick(1);
    send_req(1'b0, 1'b1, 8'h11);
    rd_rst = 1'b1;
    send_req(1'b0, 1'b0, 8'h00);
    rd_rst = 1'b0;
    check("rdrst_rewind", play_pos, 0);
    send_req(1'b0, 1'b1, 8'h11);
    check("after_rdrst_pos", play_pos, 1);

    // Slot 1 two-note song and its end; slot 2 is empty.
    slot_sel = 2'd1;
    tick(1);
    send_req(1'b0, 1'b1, 8'h5A);
    send_req(1'b0, 1'b1, 8'hA5);
`ifdef SONG_LOOP_EN
    send_req(1'b1, 1'b1, 8'h5A);
    last_note = 8'h5A;
`else
    send_req(1'b1, 1'b0, 8'h00);
    last_note = 8'hA5;
`endif
    slot_sel = 2'd2;
    tick(1);
    check("empty_len", song_len, 0);
    send_req(1'b1, 1'b0, 8'h00);
    check("empty_play_pos", play_pos, 0);

    // Abandoned fetch: leave play mode while the read is in flight.
    slot_sel = 2'd0;
    tick(1);
    rd_req = 1'b1;
    tick(1);
    rd_req = 1'b0;
    mode   = MODE_IDLE;
    tick(3);
    check("abandon_rd_data", rd_data, last_note);

    tick(4);
    check("scoreboard_drained", q_exp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
